pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 96 +++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with flush.
// Each stage holds one beat. Bubbles collapse when a downstream stage can
// take data, and backpressure stalls stages in place without losing data.
// A bubble keeps the stale contents of the data register. Only the valid
// bit is cleared, so the data path carries no enable beyond the load strobe.
module pipe_reg #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v;      // stage valid bits
    logic [DEPTH-1:0][WIDTH-1:0] d;      // stage data registers
    logic [DEPTH-1:0]            adv;    // stage takes whatever its source offers
    logic [DEPTH-1:0]            src_v;  // valid offered to each stage
    logic [DEPTH-1:0][WIDTH-1:0] src_d;  // data offered to each stage
    logic [DEPTH-1:0]            v_nxt;
    logic [DEPTH-1:0]            ld;     // data register load strobe
    logic [CW-1:0]               cnt_nxt;
    logic                        up;     // advance of the stage above

    // Stage 0 is fed from the input port. Every other stage is fed from the stage below it.
    assign src_v[0] = in_valid;
    assign src_d[0] = in_data;
    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_src
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
        end
    endgenerate

    // Advance ripples down from the output. A stage moves if it is empty or the one above moves.
    // Next-state valids, data loads and the next count are all computed here.
    always_comb begin
        adv     = '0;
        v_nxt   = '0;
        ld      = '0;
        cnt_nxt = '0;
        up      = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            adv[i] = ~v[i] | up;
            up     = adv[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush)
                v_nxt[i] = 1'b0;
            else if (adv[i])
                v_nxt[i] = src_v[i];
            else
                v_nxt[i] = v[i];
            ld[i]   = adv[i] & src_v[i] & ~flush;
            cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
        end
    end

    // Valid bits and occupancy count. Flush is already folded into v_nxt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            count <= '0;
        end else begin
            v     <= v_nxt;
            count <= cnt_nxt;
        end
    end

    // Data registers load only when real data arrives. A bubble or a flush keeps the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ld[i]) d[i] <= src_d[i];
        end
    end

    // Ready is combinational from out_ready through the advance chain.
    // It is gated off during flush and reset.
    assign in_ready  = adv[0] & ~flush & ~rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
